blit_cmd_port: RTL and testbench

BLIT_CMD_PORT -- requirements
Module: blit_cmd_port

---
 rtl/blit_pkg.sv | 23 ++
 rtl/blit_cmd_port.sv | 125 ++++++++++++
 tb/tb_blit_cmd_port.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/blit_pkg.sv
// Shared blitter definitions: register window offsets, port FSM states, slot helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package blit_pkg;

  localparam logic [3:0] ADDR_CMD_W0 = 4'd0;
  localparam logic [3:0] ADDR_CMD_W1 = 4'd1;
  localparam logic [3:0] ADDR_CMD_W2 = 4'd2;
  localparam logic [3:0] ADDR_STATUS = 4'd3;
  localparam logic [3:0] ADDR_SLOTS  = 4'd4;
  localparam logic [3:0] ADDR_COUNT  = 4'd5;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } blit_state_t;

  // Decrement that stops at zero instead of wrapping to 255.
  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

endpackage

// File: rtl/blit_cmd_port.sv
// CPU register window that assembles 96-bit blitter commands and pushes them to the command FIFO.
// Latency: a CMD_W2 write in cycle N pushes in cycle N+1 when the FIFO has room; reads return the cycle after the strobe.
// Backpressure: command-word writes stall while a command is pending (STALL_ON_FULL=1) or the command is dropped and flagged (STALL_ON_FULL=0).
module blit_cmd_port
  import blit_pkg::*;
#(
  parameter int STALL_ON_FULL = 1,
  parameter int MIN_SLOTS     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hwreg_write,
  input  logic        hwreg_read,
  input  logic [3:0]  hwreg_addr,
  input  logic [31:0] hwreg_wdata,
  output logic [31:0] hwreg_rdata,
  output logic        hwreg_stall,
  output logic [95:0] blit_cmd,
  output logic        blit_cmd_valid,
  input  logic [7:0]  blit_fifo_slots_free,
  input  logic [31:0] blit_status
);

  localparam logic [7:0] MIN_SLOTS_V = 8'(MIN_SLOTS);
  localparam bit         DROP_MODE   = (STALL_ON_FULL == 0);

  blit_state_t state;
  logic [31:0] w0_q;
  logic [31:0] w1_q;
  logic [95:0] pend_q;
  logic [31:0] count_q;
  logic        drop_q;
  logic        post_issue_q;

  logic [7:0]  eff_slots;
  logic        is_pending;
  logic        room;
  logic        issue;
  logic        drop;
  logic        wr_ok;
  logic        rd_status;

  // Status bits 2 and 0 are replaced by port-local flags in the STATUS view.
  logic unused_status;
  assign unused_status = blit_status[2] ^ blit_status[0];

  // Issue/drop decisions and write acceptance; valid comes straight from registered state so W2 at N pushes at N+1.
  always_comb begin
    eff_slots      = post_issue_q ? sat_dec(blit_fifo_slots_free) : blit_fifo_slots_free;
    is_pending     = (state == ST_PENDING);
    room           = (eff_slots >= MIN_SLOTS_V);
    issue          = is_pending && room && !reset;
    drop           = DROP_MODE && is_pending && !room && !reset;
    hwreg_stall    = hwreg_write && is_pending && (hwreg_addr <= ADDR_CMD_W2) && !drop && !reset;
    wr_ok          = hwreg_write && !hwreg_stall && !reset;
    rd_status      = hwreg_read && (hwreg_addr == ADDR_STATUS);
    blit_cmd_valid = issue;
    blit_cmd       = pend_q;
  end

  // Command FSM: a CMD_W2 write latches the command; issue or drop returns to idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      pend_q <= '0;
    end else if (wr_ok && hwreg_addr == ADDR_CMD_W2) begin
      pend_q <= {hwreg_wdata, w1_q, w0_q};
      state  <= ST_PENDING;
    end else if (issue || drop) begin
      state  <= ST_IDLE;
    end
  end

  // Low command words persist across commits so repeats only need a W2 write.
  always_ff @(posedge clock) begin
    if (reset) begin
      w0_q <= '0;
      w1_q <= '0;
    end else if (wr_ok && hwreg_addr == ADDR_CMD_W0) begin
      w0_q <= hwreg_wdata;
    end else if (wr_ok && hwreg_addr == ADDR_CMD_W1) begin
      w1_q <= hwreg_wdata;
    end
  end

  // Issue counter, sticky drop flag and the post-issue marker for FIFO count latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q      <= '0;
      drop_q       <= 1'b0;
      post_issue_q <= 1'b0;
    end else begin
      post_issue_q <= issue;
      if (wr_ok && hwreg_addr == ADDR_COUNT) begin
        count_q <= issue ? 32'd1 : 32'd0;
      end else if (issue) begin
        count_q <= count_q + 32'd1;
      end
      // A drop in the same cycle as a STATUS read keeps the flag set.
      if (drop) begin
        drop_q <= 1'b1;
      end else if (rd_status) begin
        drop_q <= 1'b0;
      end
    end
  end

  // Registered read data; holds its value between reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      hwreg_rdata <= '0;
    end else if (hwreg_read) begin
      case (hwreg_addr)
        ADDR_CMD_W0: hwreg_rdata <= w0_q;
        ADDR_CMD_W1: hwreg_rdata <= w1_q;
        ADDR_CMD_W2: hwreg_rdata <= pend_q[95:64];
        ADDR_STATUS: hwreg_rdata <= {blit_status[31:3], drop_q, blit_status[1], is_pending};
        ADDR_SLOTS:  hwreg_rdata <= {24'b0, eff_slots};
        ADDR_COUNT:  hwreg_rdata <= count_q;
        default:     hwreg_rdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_blit_cmd_port.sv
// Self-checking bench: stall-mode port on a queue scoreboard, drop-mode port with directed checks.
// Latency: expects a push one cycle after each accepted CMD_W2 write when room exists.
// Backpressure: raises FIFO slots when the port stays stalled so every wait is bounded.
module tb_blit_cmd_port;

  logic        clk;
  logic        rst;
  logic [31:0] status;

  logic        wr, rd, stall, vld;
  logic [3:0]  addr;
  logic [31:0] wdata, rdata;
  logic [95:0] cmd;
  logic [7:0]  slots;

  logic        d0_wr, d0_rd, d0_stall, d0_vld;
  logic [3:0]  d0_addr;
  logic [31:0] d0_wdata, d0_rdata;
  logic [95:0] d0_cmd;
  logic [7:0]  d0_slots;

  blit_cmd_port #(.STALL_ON_FULL(1), .MIN_SLOTS(1)) dut1 (
    .clock(clk), .reset(rst), .hwreg_write(wr), .hwreg_read(rd), .hwreg_addr(addr),
    .hwreg_wdata(wdata), .hwreg_rdata(rdata), .hwreg_stall(stall), .blit_cmd(cmd),
    .blit_cmd_valid(vld), .blit_fifo_slots_free(slots), .blit_status(status)
  );

  blit_cmd_port #(.STALL_ON_FULL(0), .MIN_SLOTS(1)) dut0 (
    .clock(clk), .reset(rst), .hwreg_write(d0_wr), .hwreg_read(d0_rd), .hwreg_addr(d0_addr),
    .hwreg_wdata(d0_wdata), .hwreg_rdata(d0_rdata), .hwreg_stall(d0_stall), .blit_cmd(d0_cmd),
    .blit_cmd_valid(d0_vld), .blit_fifo_slots_free(d0_slots), .blit_status(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_w0, m_w1, m_count;
  logic [95:0] exp_cmd[$];
  logic [31:0] exp_rd[$];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not allowed here", name);
  endtask

  function automatic logic [31:0] st_val(input logic [31:0] s, input logic dropf, input logic pend);
    return {s[31:3], dropf, s[1], pend};
  endfunction

  function automatic logic [7:0] sat1(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

  // Monitor: pops expected commands and read data whenever the DUT presents them.
  logic rd_seen = 1'b0;
  logic prev_vld = 1'b0;
  always @(posedge clk) rd_seen <= rd && !rst;

  always @(negedge clk) begin
    if (!rst) begin
      if (vld) begin
        if (exp_cmd.size() == 0) fail("unexpected_valid");
        else chk("blit_cmd", cmd, exp_cmd.pop_front());
        chk("no_double_issue_one_slot", {95'b0, prev_vld && (slots < 8'd2)}, 96'd0);
      end
      if (rd_seen) begin
        if (exp_rd.size() == 0) fail("unexpected_read");
        else chk("rdata", {64'b0, rdata}, {64'b0, exp_rd.pop_front()});
      end
    end
    prev_vld = vld && !rst;
  end

  // Write with stall handling; called and returns just after a rising edge.
  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    int n;
    n = 0;
    wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    while (stall) begin
      n++;
      if (n == 4 && slots == 8'd0) slots = 8'($urandom_range(1, 8));
      if (n > 60) begin
        fail("write_stall_timeout");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    wr = 1'b0;
    if (a == 4'd0) m_w0 = d;
    if (a == 4'd1) m_w1 = d;
    if (a == 4'd2) begin
      exp_cmd.push_back({d, m_w1, m_w0});
      m_count = m_count + 32'd1;
    end
    if (a == 4'd5) m_count = 32'd0;
  endtask

  task automatic rd_reg(input logic [3:0] a, input logic [31:0] e);
    rd = 1'b1; addr = a;
    exp_rd.push_back(e);
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  // Waits until every committed command has been pushed; returns in the cycle after the last push.
  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_cmd.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (n == 3 && slots == 8'd0) slots = 8'($urandom_range(1, 8));
    end
    if (exp_cmd.size() != 0) fail("issue_timeout");
  endtask

  task automatic d0_cycle();
    @(posedge clk); #1;
    d0_wr = 1'b0; d0_rd = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] dv, dz, dl;
    logic [3:0]  ua;
    rst = 1'b1; status = 32'hA5A5_5A5F;
    wr = 0; rd = 0; addr = 0; wdata = 0; slots = 8'd8;
    d0_wr = 0; d0_rd = 0; d0_addr = 0; d0_wdata = 0; d0_slots = 8'd0;
    m_w0 = 0; m_w1 = 0; m_count = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {95'b0, vld}, 96'd0);
    chk("rst_stall", {95'b0, stall}, 96'd0);
    chk("rst_cmd", cmd, 96'd0);
    chk("rst_rdata", {64'b0, rdata}, 96'd0);
    chk("rst_d0_cmd", d0_cmd, 96'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    rd_reg(4'd5, 32'd0);
    rd_reg(4'd3, st_val(status, 1'b0, 1'b0));
    rd_reg(4'd4, 32'd8);

    // Basic commit and one-cycle latency
    wr_reg(4'd0, 32'h1111_1111);
    wr_reg(4'd1, 32'h2222_2222);
    wr_reg(4'd2, 32'h3333_3333);
    @(negedge clk);
    chk("latency_valid", {95'b0, vld}, 96'd1);
    chk("cmd_value", cmd, 96'h3333_3333_2222_2222_1111_1111);
    @(negedge clk);
    chk("single_pulse", {95'b0, vld}, 96'd0);
    @(posedge clk); #1;

    // Effective slots drop by one only in the cycle after an issue
    slots = 8'd5;
    wr_reg(4'd2, 32'hAAAA_0001);
    rd_reg(4'd4, 32'd5);
    rd_reg(4'd4, 32'd4);
    rd_reg(4'd4, 32'd5);

    // Saturation at zero
    slots = 8'd1;
    wr_reg(4'd2, 32'hAAAA_0002);
    rd_reg(4'd4, 32'd1);
    slots = 8'd0;
    rd_reg(4'd4, 32'd0);
    rd_reg(4'd4, 32'd0);

    // Full FIFO: command waits, W0 stalls, STATUS readable while pending
    wr_reg(4'd2, 32'hAAAA_0003);
    rd_reg(4'd3, st_val(status, 1'b0, 1'b1));
    dv = 32'h4444_4444;
    wr = 1'b1; addr = 4'd0; wdata = dv;
    repeat (3) begin
      @(negedge clk);
      chk("stall_held", {95'b0, stall}, 96'd1);
    end
    @(posedge clk); #1;
    slots = 8'd3;
    @(negedge clk);
    chk("stall_in_issue_cycle", {95'b0, stall}, 96'd1);
    chk("issue_on_room", {95'b0, vld}, 96'd1);
    @(negedge clk);
    chk("stall_released", {95'b0, stall}, 96'd0);
    @(posedge clk); #1;
    wr = 1'b0;
    m_w0 = dv;
    wr_reg(4'd2, 32'hAAAA_0004);
    wait_idle();

    // Back-to-back commits with a single slot
    slots = 8'd1;
    wr_reg(4'd2, 32'hBBBB_0001);
    wr_reg(4'd2, 32'hBBBB_0002);
    wait_idle();

    // Counter wrap: preload all-ones, one more issue reads zero
    slots = 8'd8;
    @(posedge clk); #1;
    force dut1.count_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut1.count_q;
    m_count = 32'hFFFF_FFFF;
    wr_reg(4'd2, 32'hCCCC_0001);
    wait_idle();
    rd_reg(4'd5, m_count);
    // COUNT clear coinciding with an issue leaves one
    wr_reg(4'd2, 32'hCCCC_0002);
    wr_reg(4'd5, 32'h0);
    m_count = 32'd1;
    rd_reg(4'd5, 32'd1);
    wr_reg(4'd5, 32'h1234);
    rd_reg(4'd5, 32'd0);

    // Unmapped offsets
    wr_reg(4'd7, 32'hDEAD_BEEF);
    rd_reg(4'd7, 32'd0);
    rd_reg(4'd15, 32'd0);

    // Drop mode: full FIFO drops, flag survives a same-cycle STATUS read
    dz = 32'h5555_AAAA;
    d0_wr = 1'b1; d0_addr = 4'd2; d0_wdata = 32'h9999_0000;
    d0_cycle();
    d0_rd = 1'b1; d0_addr = 4'd3;
    d0_wr = 1'b1; d0_wdata = dz;
    #1 d0_addr = 4'd0;
    d0_rd = 1'b0;
    // read STATUS first cycle via separate strobe on same address not possible; read next
    @(negedge clk);
    chk("d0_no_stall_on_drop", {95'b0, d0_stall}, 96'd0);
    chk("d0_no_valid_on_drop", {95'b0, d0_vld}, 96'd0);
    d0_cycle();
    d0_rd = 1'b1; d0_addr = 4'd3;
    d0_cycle();
    @(negedge clk);
    chk("d0_status_drop_set", {64'b0, d0_rdata}, {64'b0, st_val(status, 1'b1, 1'b0)});
    d0_rd = 1'b1; d0_addr = 4'd3;
    d0_cycle();
    @(negedge clk);
    chk("d0_status_drop_cleared", {64'b0, d0_rdata}, {64'b0, st_val(status, 1'b0, 1'b0)});
    // Drop coinciding with a STATUS read: flag must stay set
    d0_wr = 1'b1; d0_addr = 4'd2; d0_wdata = 32'h9999_0001;
    d0_cycle();
    d0_rd = 1'b1; d0_addr = 4'd3;
    d0_cycle();
    @(negedge clk);
    chk("d0_status_in_drop_cycle", {64'b0, d0_rdata}, {64'b0, st_val(status, 1'b0, 1'b1)});
    d0_rd = 1'b1; d0_addr = 4'd3;
    d0_cycle();
    @(negedge clk);
    chk("d0_drop_wins_over_read", {64'b0, d0_rdata}, {64'b0, st_val(status, 1'b1, 1'b0)});
    // With room, drop-mode port issues normally; W0 written during the first drop cycle
    d0_slots = 8'd4;
    dl = 32'h7777_0001;
    d0_wr = 1'b1; d0_addr = 4'd2; d0_wdata = dl;
    d0_cycle();
    @(negedge clk);
    chk("d0_issue_valid", {95'b0, d0_vld}, 96'd1);
    chk("d0_issue_cmd", d0_cmd, {dl, 32'h0, dz});
    @(posedge clk); #1;

    // Randomized commits against the model
    for (int it = 0; it < 40; it++) begin
      status = $urandom;
      slots  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if ($urandom_range(0, 1) == 1) wr_reg(4'd0, $urandom);
      if ($urandom_range(0, 1) == 1) wr_reg(4'd1, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        ua = ($urandom_range(0, 1) == 1) ? 4'd3 : 4'($urandom_range(6, 15));
        wr_reg(ua, $urandom);
      end
      wr_reg(4'd2, $urandom);
      wait_idle();
      rd_reg(4'd4, {24'b0, sat1(slots)});
      rd_reg(4'd3, st_val(status, 1'b0, 1'b0));
      rd_reg(4'd5, m_count);
      if ($urandom_range(0, 2) == 0) rd_reg(4'($urandom_range(6, 15)), 32'd0);
    end

    // Reset while a command is pending discards it
    slots = 8'd0;
    wr_reg(4'd2, 32'hEEEE_0001);
    rst = 1'b1;
    exp_cmd.delete();
    m_w0 = 0; m_w1 = 0; m_count = 0;
    slots = 8'd8;
    @(negedge clk);
    chk("rst_pend_no_valid", {95'b0, vld}, 96'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_pend_rdata", {64'b0, rdata}, 96'd0);
    chk("rst_pend_cmd", cmd, 96'd0);
    chk("rst_pend_stall", {95'b0, stall}, 96'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("no_valid_after_reset", {95'b0, vld}, 96'd0);
    end
    @(posedge clk); #1;
    rd_reg(4'd5, 32'd0);
    rd_reg(4'd3, st_val(status, 1'b0, 1'b0));
    rd_reg(4'd4, 32'd8);
    wr_reg(4'd2, 32'hEEEE_0002);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    if (exp_rd.size() != 0) fail("reads_outstanding");
    if (exp_cmd.size() != 0) fail("commands_outstanding");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
